// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter sequencer.
//   - pc_src_e   : next-PC source selected by the priority logic
//   - RAS_PTR_W  : return-stack pointer width for the default depth
//   - ras_ptr_width(): pointer width for any power-of-two depth
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_CALL   = 3'd3,
        SRC_RET    = 3'd4
    } pc_src_e;

    localparam int unsigned RAS_DEPTH_DFLT = 32'd4;
    localparam int unsigned RAS_PTR_W      = $clog2(RAS_DEPTH_DFLT);

    // Pointer width for a circular stack of the given (power-of-two) depth.
    function automatic int unsigned ras_ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   Ports:
//     clk, rst        clock (rising edge), async active-high reset
//     push_i          push push_data_i (overwrites oldest entry when full)
//     pop_i           pop top entry (ignored when empty)
//     push_data_i     value to push
//     top_data_o      current top-of-stack value (valid when !empty_o)
//     empty_o         no valid entries
//     count_o         number of valid entries (registered)
//     full_o          count_o == DEPTH (registered)
//   Entries are never cleared; only pointer and count reset.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned DATA_W = 32'd16,
    parameter int unsigned DEPTH  = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          push_data_i,
    output logic [DATA_W-1:0]          top_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int unsigned PTR_W = ras_ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;      // next free slot; top is ptr_q-1
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic [PTR_W-1:0]  top_idx_s;

    assign top_idx_s  = ptr_q - PTR_W'(1);
    assign top_data_o = mem_q[top_idx_s];
    assign empty_o    = (count_q == CNT_W'(0));
    assign count_o    = count_q;
    assign full_o     = full_q;

    // Pointer/count next state; pointer wraps naturally, so a push when
    // full lands on the oldest entry while the count saturates.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (pop_i && !empty_o) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end else if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH)) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            ptr_d   = ptr_q;
            count_d = count_q;
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, count and full flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Entry storage; no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (push_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program counter with branch/jump/call/return selection and
// a circular return-address stack.
//   Ports:
//     clk, rst         clock (rising edge), async active-high reset
//     enable           1 = state may update; 0 = stall
//     i_branch/i_jump/i_call/i_ret  redirect requests (ret > call > jump > branch)
//     i_target         absolute target for jump/call
//     i_offset         two's-complement branch offset
//     o_pc             current PC
//     o_ras_count      valid return-stack entries
//     o_ras_full       return stack full
//     o_ret_err        one-cycle pulse after a return with empty stack
//     o_redirect_cnt   taken-redirect counter
//   Optional macro PC_PERF_CNT_EN builds the saturating redirect counter;
//   without it o_redirect_cnt is tied to zero.
module pc_seq_unit
    import pc_pkg::*;
#(
    parameter int unsigned CONTENT_SIZE = 32'd16,
    parameter int unsigned PC_STEP      = 32'd1,
    parameter int unsigned RESET_VECTOR = 32'd0,
    parameter int unsigned RAS_DEPTH    = 32'd4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           i_branch,
    input  logic                           i_jump,
    input  logic                           i_call,
    input  logic                           i_ret,
    input  logic [CONTENT_SIZE-1:0]        i_target,
    input  logic [CONTENT_SIZE-1:0]        i_offset,
    output logic [CONTENT_SIZE-1:0]        o_pc,
    output logic [$clog2(RAS_DEPTH+1)-1:0] o_ras_count,
    output logic                           o_ras_full,
    output logic                           o_ret_err,
    output logic [15:0]                    o_redirect_cnt
);

    logic [CONTENT_SIZE-1:0] pc_q, pc_d;
    logic                    ret_err_q, ret_err_d;
    logic [CONTENT_SIZE-1:0] seq_pc_s;
    logic [CONTENT_SIZE-1:0] ras_top_s;
    logic                    ras_empty_s;
    logic                    push_s, pop_s;
    pc_src_e                 src_s;

    assign seq_pc_s = pc_q + CONTENT_SIZE'(PC_STEP);

    // Priority select; a return on an empty stack falls back to the
    // sequential step so it neither pops nor counts as a redirect.
    always_comb begin
        src_s = SRC_SEQ;
        if (i_ret) begin
            if (ras_empty_s) begin
                src_s = SRC_SEQ;
            end else begin
                src_s = SRC_RET;
            end
        end else if (i_call) begin
            src_s = SRC_CALL;
        end else if (i_jump) begin
            src_s = SRC_JUMP;
        end else if (i_branch) begin
            src_s = SRC_BRANCH;
        end else begin
            src_s = SRC_SEQ;
        end
    end

    // Next PC, stack handshake and return-error pulse.
    always_comb begin
        case (src_s)
            SRC_RET:    pc_d = ras_top_s;
            SRC_CALL:   pc_d = i_target;
            SRC_JUMP:   pc_d = i_target;
            SRC_BRANCH: pc_d = pc_q + i_offset;
            default:    pc_d = seq_pc_s;
        endcase
        if (!enable) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_d;
        end
        push_s    = enable && (src_s == SRC_CALL);
        pop_s     = enable && (src_s == SRC_RET);
        ret_err_d = enable && i_ret && ras_empty_s;
    end

    // PC and return-error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= CONTENT_SIZE'(RESET_VECTOR);
            ret_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ret_err_q <= ret_err_d;
        end
    end

    assign o_pc      = pc_q;
    assign o_ret_err = ret_err_q;

    ras_stack #(
        .DATA_W (CONTENT_SIZE),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (seq_pc_s),
        .top_data_o  (ras_top_s),
        .empty_o     (ras_empty_s),
        .count_o     (o_ras_count),
        .full_o      (o_ras_full)
    );

`ifdef PC_PERF_CNT_EN
    logic [15:0] redir_cnt_q, redir_cnt_d;

    // Saturating count of enabled cycles that leave the sequential path.
    always_comb begin
        if (enable && (src_s != SRC_SEQ) && (redir_cnt_q != 16'hFFFF)) begin
            redir_cnt_d = redir_cnt_q + 16'd1;
        end else begin
            redir_cnt_d = redir_cnt_q;
        end
    end

    // Redirect counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_cnt_q <= 16'h0000;
        end else begin
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign o_redirect_cnt = redir_cnt_q;
`else
    assign o_redirect_cnt = 16'h0000;
`endif

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised next-generation program counter. It holds the PC and selects the next PC from four sources: sequential step, relative branch, absolute jump/call, and return. A small circular return-address stack (RAS) supplies the return addresses. It sits at the head of the fetch path: it drives the instruction memory address and takes its redirect inputs from decode/execute.

Parameters:
CONTENT_SIZE, 16, PC width in bits; all PC arithmetic is modulo 2^CONTENT_SIZE
PC_STEP, 1, sequential increment, in address units
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries; must be ≥2 and a power of two

Ports:
clk  input  1  clock, rising edge active
rst  input  1  reset, asynchronous, active-high
enable  input  1  1 = PC/RAS may update this cycle; 0 = stall (hold all state)
i_branch  input  1  take relative branch
i_jump  input  1  absolute jump to i_target
i_call  input  1  absolute jump to i_target and push o_pc+PC_STEP
i_ret  input  1  pop RAS and jump to popped address
i_target  input  CONTENT_SIZE  absolute target for jump/call
i_offset  input  CONTENT_SIZE  two's-complement branch offset, added to o_pc
o_pc  output  CONTENT_SIZE  current PC
o_ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
o_ras_full  output  1  o_ras_count == RAS_DEPTH
o_ret_err  output  1  one-cycle pulse: return attempted with empty RAS
o_redirect_cnt  output  16  taken-redirect counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - o_pc=RESET_VECTOR, RAS pointer=0, o_ras_count=0, o_ras_full=0, o_ret_err=0, o_redirect_cnt=0.
  - Entries need not be cleared.
  - Reset asserted mid-operation overrides everything, including a pending call/ret.
- All state updates on the rising clk edge only when enable=1. With enable=0, o_pc, RAS contents/pointer/count and the counter hold, and o_ret_err goes to 0.
- Next-PC priority, highest first (enable=1):
  - i_ret: if count>0, pc←RAS[top], pop. If count==0, pc←o_pc+PC_STEP and o_ret_err=1 next cycle.
  - i_call: pc←i_target, push o_pc+PC_STEP.
  - i_jump: pc←i_target.
  - i_branch: pc←o_pc+i_offset.
  - otherwise: pc←o_pc+PC_STEP.
- Lower-priority requests asserted in the same cycle are ignored entirely; e.g. i_ret+i_call pops only, no push.
- Arithmetic wraps modulo 2^CONTENT_SIZE: 0xFFFF+1→0x0000; 0x0002+0xFFFD→0xFFFF.
- RAS is a circular buffer with top pointer width log2(RAS_DEPTH).
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop decrements count; after overflow, pops beyond RAS_DEPTH report empty (o_ret_err).
- Latency: a redirect presented in cycle N is visible on o_pc in cycle N+1. No bubbles.
- o_ras_full and o_ras_count are registered and consistent with the stack after each edge.

Optional Feature:
PC_PERF_CNT_EN:
- Defined: o_redirect_cnt increments by 1 on each enabled cycle whose next PC is not the sequential step, i.e. branch, jump, call, or successful ret. A failed ret (o_ret_err) does not count. The counter saturates at 0xFFFF and is cleared by rst.
- Undefined: no counter register is built and o_redirect_cnt is tied to 0.

Decomposition:
- Shared package pc_pkg holds:
  - the next-PC source encoding (SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_CALL, SRC_RET) used by the priority select;
  - the localparam for pointer width.
- One sub-module ras_stack: circular storage, pointer, count, full, and push/pop/empty handshake.
- pc_seq_unit holds the priority select, PC register and counter.

Test Plan:
1. rst pulsed asynchronously between edges with RESET_VECTOR=0x0100 → o_pc=0x0100 immediately; 3 idle enabled cycles → 0x0101, 0x0102, 0x0103.
2. From o_pc=0x0010: call i_target=0x0200 → o_pc=0x0200, count=1; 2 seq cycles; ret → o_pc=0x0011, count=0.
3. 5 calls with RAS_DEPTH=4 → o_ras_full=1, count=4; 4 rets return the last 4 pushes in LIFO order; 5th ret → o_pc=pc+1, o_ret_err=1 for exactly one cycle.
4. enable=0 for 3 cycles with i_jump=1, i_target=0x0ABC → o_pc, count and counter unchanged; enable=1 → o_pc=0x0ABC next cycle.
5. o_pc=0x0002, i_branch, i_offset=0xFFFD → 0xFFFF; then seq → 0x0000. Simultaneous i_ret+i_call with count=1 → pop only, count=0.
6. With PC_PERF_CNT_EN: 2 jumps, 1 branch, 1 failed ret → o_redirect_cnt=3. Without it, o_redirect_cnt stays 0.
